instruction_prefetch: RTL and testbench
=======================================

Name: instruction_prefetch

Overview:
- Parametrised successor to the single-register fetcher: decouples memory reads from decode with a DEPTH-word prefetch queue.
- Assembles 1- and 2-word instructions using a configurable long-opcode mask and presents them on a valid/ready interface to the decoder.
- On a jump it flushes the queue and discards in-flight reads, so no wrong-path NOP cycles are issued.
- Sits between main RAM (fixed 1-cycle read latency) and the decoder.

Parameters:
WORD_WIDTH, 16, memory word / instruction word width
ADDR_WIDTH, 16, program counter and memory address width
OPCODE_WIDTH, 4, opcode field width, located at bits [WORD_WIDTH-1 : WORD_WIDTH-OPCODE_WIDTH]
LONG_OP_MASK, 16'h0000, 2**OPCODE_WIDTH bits; bit i=1 marks opcode i as a 2-word instruction
DEPTH, 4, prefetch queue depth in words; power of two, >=2
RESET_PC, 0, fetch address after reset

Ports:
gclk  in  1  global clock, all state on rising edge
nReset  in  1  synchronous active-low reset
MemReq  out  1  read request this cycle
MemAddr  out  ADDR_WIDTH  read address, valid when MemReq=1
MemRead  in  WORD_WIDTH  read data, valid exactly one cycle after MemReq
JumpFlag  in  1  redirect fetch this cycle
JumpTypeFlag  in  1  1=absolute (JUMP_FAR), 0=relative
JumpAddrSign  in  1  relative only: 1=subtract, 0=add
JumpAddr  in  ADDR_WIDTH  absolute target or relative magnitude
OutValid  out  1  instruction available
OutReady  in  1  decoder accepts (replaces stall; stall = !OutReady)
OutDataBus  out  2*WORD_WIDTH  {second word, first word}; upper half 0 for 1-word ops
OutLong  out  1  1 when OutDataBus holds a 2-word instruction
OutPC  out  ADDR_WIDTH  address of first word of presented instruction

Behaviour:
- Clock is gclk. Reset is synchronous and active-low on nReset; there is one clock domain.
- Reset (nReset=0 at edge): queue empty, pending=0, FetchPC=RESET_PC, BasePC=RESET_PC. While nReset=0: MemReq=0, OutValid=0, OutDataBus=0, OutLong=0, OutPC=0.
- Reset mid-operation discards the queue and any in-flight read.
- Queue entries hold {addr, word}; count ranges 0..DEPTH; head/tail pointers wrap mod DEPTH.
- Request: MemReq = nReset & !JumpFlag & (count + pending < DEPTH); MemAddr = FetchPC.
- Pops in the same cycle are not credited.
- Issuing a request sets pending=1 and FetchPC <= FetchPC+1 mod 2^ADDR_WIDTH.
- Response: in the cycle after a request (pending=1), MemRead is pushed with its address, unless a flush occurred in the request-to-response window. A flushed response is dropped.
- Latency: request at cycle t, data enters queue at end of t+1, OutValid can assert at t+2.
- Assembly is combinational from the queue head:
  - head opcode long (LONG_OP_MASK[op]=1): OutValid = count>=2, OutDataBus={word[head+1], word[head]}, OutLong=1.
  - otherwise: OutValid = count>=1, OutDataBus={0, word[head]}, OutLong=0.
  - OutPC = addr[head].
  - When OutValid=0, OutDataBus=0.
- Handshake: on OutValid & OutReady, pop 1 or 2 entries and set BasePC <= OutPC + (OutLong?2:1).
- Outputs hold stable while OutValid=1 and OutReady=0.
- Push and pop in the same cycle are both applied; count updates by push-pop.
- Jump (JumpFlag=1 at edge, overrides OutReady):
  - queue flushed, any pending response discarded.
  - absolute: FetchPC <= JumpAddr.
  - relative: FetchPC <= BasePC ± JumpAddr, mod 2^ADDR_WIDTH.
  - BasePC <= new FetchPC. No pop occurs even if OutValid & OutReady that cycle.
  - Request for the target is issued the following cycle; first target instruction OutValid 3 cycles after the jump edge.
- A 2-word instruction whose second word has not yet arrived stays invalid and is never emitted split.
- FetchPC and relative arithmetic wrap silently at 2^ADDR_WIDTH.

Test Plan:
- Reset then stream of 1-word ops at RAM 0..7 with OutReady=1 -> OutValid first high at cycle 2 after reset release; OutPC 0,1,2…, one per cycle, OutLong=0.
- LONG_OP_MASK bit for opcode 4'h5 set, RAM[0]=16'h5123, RAM[1]=16'hBEEF -> single beat OutDataBus=32'hBEEF5123, OutLong=1, OutPC=0, next OutPC=2.
- OutReady=0 for 10 cycles -> MemReq stops once count=DEPTH (4); outputs stable; no word lost or duplicated after release.
- Absolute jump JumpAddr=16'h0040 while queue full -> queue empty next cycle, stale response dropped, first OutPC=16'h0040.
- Relative jump, sign=1, JumpAddr=3 after accepting the 1-word op at 16'h0010 -> next OutPC=16'h000E. Repeat with FetchPC near 16'hFFFF: wraps to 16'h0000.
- nReset=0 asserted for one cycle mid-stream with a pending read -> OutValid=0 next cycle, fetch restarts at RESET_PC, old data never appears.

Source files
------------

// File: rtl/instruction_prefetch.sv
// Instruction prefetch: DEPTH-word queue between 1-cycle-latency RAM and the decoder.
// Assembles 1/2-word instructions onto a valid/ready port; jumps flush queue and in-flight reads.
module instruction_prefetch #(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned OPCODE_WIDTH = 4,
  parameter logic [2**OPCODE_WIDTH-1:0] LONG_OP_MASK = '0,
  parameter int unsigned DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                    gclk,
  input  logic                    nReset,
  output logic                    MemReq,
  output logic [ADDR_WIDTH-1:0]   MemAddr,
  input  logic [WORD_WIDTH-1:0]   MemRead,
  input  logic                    JumpFlag,
  input  logic                    JumpTypeFlag,
  input  logic                    JumpAddrSign,
  input  logic [ADDR_WIDTH-1:0]   JumpAddr,
  output logic                    OutValid,
  input  logic                    OutReady,
  output logic [2*WORD_WIDTH-1:0] OutDataBus,
  output logic                    OutLong,
  output logic [ADDR_WIDTH-1:0]   OutPC
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WORD_WIDTH-1:0] qWord [DEPTH];
  logic [ADDR_WIDTH-1:0] qAddr [DEPTH];
  logic [PTR_W-1:0]      headPtr;
  logic [PTR_W-1:0]      tailPtr;
  logic [PTR_W-1:0]      headNext;
  logic [CNT_W-1:0]      count;
  logic                  pending;
  logic [ADDR_WIDTH-1:0] pendAddr;
  logic [ADDR_WIDTH-1:0] fetchPC;
  logic [ADDR_WIDTH-1:0] basePC;

  logic [WORD_WIDTH-1:0] headWord;
  logic [WORD_WIDTH-1:0] secondWord;
  logic                  headLong;
  logic                  doPush;
  logic                  doPop;
  logic [CNT_W-1:0]      pushCnt;
  logic [CNT_W-1:0]      popCnt;
  logic [ADDR_WIDTH-1:0] jumpTarget;

  assign MemAddr = fetchPC;

  // Head assembly, request gating and queue bookkeeping
  always_comb begin
    headNext   = headPtr + PTR_W'(1);
    headWord   = qWord[headPtr];
    secondWord = qWord[headNext];
    headLong   = LONG_OP_MASK[headWord[WORD_WIDTH-1 -: OPCODE_WIDTH]];
    MemReq     = 1'b0;
    OutValid   = 1'b0;
    OutLong    = 1'b0;
    OutDataBus = '0;
    OutPC      = '0;
    if (nReset) begin
      MemReq = !JumpFlag && ((32'(count) + 32'(pending)) < DEPTH);
      OutPC  = qAddr[headPtr];
      if (headLong) begin
        OutValid = (count >= CNT_W'(2));
        OutLong  = OutValid;
        if (OutValid) OutDataBus = {secondWord, headWord};
      end else begin
        OutValid = (count >= CNT_W'(1));
        if (OutValid) OutDataBus = {WORD_WIDTH'(0), headWord};
      end
    end
    doPush  = pending && !JumpFlag;
    doPop   = OutValid && OutReady && !JumpFlag;
    pushCnt = doPush ? CNT_W'(1) : CNT_W'(0);
    popCnt  = !doPop ? CNT_W'(0) : (OutLong ? CNT_W'(2) : CNT_W'(1));
    if (JumpTypeFlag)      jumpTarget = JumpAddr;
    else if (JumpAddrSign) jumpTarget = basePC - JumpAddr;
    else                   jumpTarget = basePC + JumpAddr;
  end

  // Queue, fetch pointer and in-flight read tracking
  always_ff @(posedge gclk) begin
    if (!nReset) begin
      headPtr  <= '0;
      tailPtr  <= '0;
      count    <= '0;
      pending  <= 1'b0;
      pendAddr <= '0;
      fetchPC  <= RESET_PC;
      basePC   <= RESET_PC;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        qWord[PTR_W'(i)] <= '0;
        qAddr[PTR_W'(i)] <= '0;
      end
    end else if (JumpFlag) begin
      // Flush wins over pop and drops the read still in flight
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
      pending <= 1'b0;
      fetchPC <= jumpTarget;
      basePC  <= jumpTarget;
    end else begin
      pending <= MemReq;
      if (MemReq) begin
        fetchPC  <= fetchPC + ADDR_WIDTH'(1);
        pendAddr <= fetchPC;
      end
      if (doPush) begin
        qWord[tailPtr] <= MemRead;
        qAddr[tailPtr] <= pendAddr;
        tailPtr        <= tailPtr + PTR_W'(1);
      end
      if (doPop) begin
        headPtr <= headPtr + PTR_W'(popCnt);
        basePC  <= OutPC + (OutLong ? ADDR_WIDTH'(2) : ADDR_WIDTH'(1));
      end
      count <= count + pushCnt - popCnt;
    end
  end

endmodule

// File: tb/tb_instruction_prefetch.sv
// Directed bench for instruction_prefetch: streaming, backpressure, jumps, long ops, reset.
module tb_instruction_prefetch;

  logic        gclk;
  logic        nReset;
  logic        MemReq;
  logic [15:0] MemAddr;
  logic [15:0] MemRead;
  logic        JumpFlag;
  logic        JumpTypeFlag;
  logic        JumpAddrSign;
  logic [15:0] JumpAddr;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] OutDataBus;
  logic        OutLong;
  logic [15:0] OutPC;

  logic [15:0] ram [65536];
  int total = 0;
  int bad   = 0;

  instruction_prefetch #(
    .WORD_WIDTH(16), .ADDR_WIDTH(16), .OPCODE_WIDTH(4),
    .LONG_OP_MASK(16'h0020), .DEPTH(4), .RESET_PC(16'h0000)
  ) dut (
    .gclk(gclk), .nReset(nReset), .MemReq(MemReq), .MemAddr(MemAddr), .MemRead(MemRead),
    .JumpFlag(JumpFlag), .JumpTypeFlag(JumpTypeFlag), .JumpAddrSign(JumpAddrSign),
    .JumpAddr(JumpAddr), .OutValid(OutValid), .OutReady(OutReady),
    .OutDataBus(OutDataBus), .OutLong(OutLong), .OutPC(OutPC)
  );

  initial begin
    gclk = 1'b0;
    forever #5 gclk = ~gclk;
  end

  // RAM model with one-cycle read latency
  always @(posedge gclk) if (MemReq) MemRead <= ram[MemAddr];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic go();
    @(posedge gclk);
    #1;
  endtask

  task automatic smp();
    @(negedge gclk);
  endtask

  task automatic doJump(input logic t, input logic s, input logic [15:0] a);
    JumpFlag = 1'b1; JumpTypeFlag = t; JumpAddrSign = s; JumpAddr = a;
  endtask

  // Follows a jump cycle: two empty cycles, then the target word
  task automatic afterJump(input logic [15:0] exp);
    go(); JumpFlag = 1'b0;
    smp();
    check("jmp_t1_valid", OutValid, 0);
    check("jmp_t1_req", MemReq, 1);
    check("jmp_t1_addr", MemAddr, exp);
    go(); smp();
    check("jmp_t2_valid", OutValid, 0);
    go(); smp();
    check("jmp_t3_valid", OutValid, 1);
    check("jmp_t3_pc", OutPC, exp);
    check("jmp_t3_data", OutDataBus, {16'h0000, ram[exp]});
  endtask

  initial begin
    nReset = 1'b0; JumpFlag = 1'b0; JumpTypeFlag = 1'b0; JumpAddrSign = 1'b0;
    JumpAddr = 16'h0000; OutReady = 1'b1;
    for (int i = 0; i < 65536; i++) ram[i] = (16'(i) & 16'h0FFF) | 16'h1000;

    // Reset state
    go(); smp();
    check("rst_req", MemReq, 0);
    check("rst_valid", OutValid, 0);
    check("rst_data", OutDataBus, 0);
    check("rst_long", OutLong, 0);
    check("rst_pc", OutPC, 0);
    go(); nReset = 1'b1;
    smp();
    check("c0_req", MemReq, 1);
    check("c0_addr", MemAddr, 16'h0000);
    check("c0_valid", OutValid, 0);
    go(); smp();
    check("c1_valid", OutValid, 0);
    check("c1_addr", MemAddr, 16'h0001);

    // Stream of 1-word ops, one per cycle
    for (int k = 0; k < 8; k++) begin
      go(); smp();
      check("str_valid", OutValid, 1);
      check("str_pc", OutPC, 16'(k));
      check("str_data", OutDataBus, {16'h0000, 16'h1000 | 16'(k)});
      check("str_long", OutLong, 0);
    end

    // Backpressure: queue fills to DEPTH then requests stop, head holds
    go(); OutReady = 1'b0;
    smp();
    check("bp_pc0", OutPC, 16'h0008);
    check("bp_req0", MemReq, 1);
    for (int i = 1; i < 10; i++) begin
      go(); smp();
      check("bp_valid", OutValid, 1);
      check("bp_pc", OutPC, 16'h0008);
      check("bp_data", OutDataBus, 32'h0000_1008);
      check("bp_req", MemReq, (i < 2) ? 1'b1 : 1'b0);
    end
    go(); OutReady = 1'b1;
    for (int k = 0; k < 8; k++) begin
      smp();
      check("rel_valid", OutValid, 1);
      check("rel_pc", OutPC, 16'h0008 + 16'(k));
      go();
    end

    // Absolute jump with full queue
    OutReady = 1'b0;
    go(); go(); go(); go();
    doJump(1'b1, 1'b0, 16'h0040); OutReady = 1'b1;
    smp();
    check("full_valid", OutValid, 1);
    check("full_pc", OutPC, 16'h0010);
    check("full_req", MemReq, 0);
    afterJump(16'h0040);

    // Relative subtract after accepting the op at 0x0010
    go(); doJump(1'b1, 1'b0, 16'h0010);
    smp();
    check("pre10_pc", OutPC, 16'h0041);
    afterJump(16'h0010);
    go(); doJump(1'b0, 1'b1, 16'h0003);
    smp();
    check("nopop_pc", OutPC, 16'h0011);
    afterJump(16'h000E);

    // Address wrap: sequential fetch and relative arithmetic both directions
    go(); doJump(1'b1, 1'b0, 16'hFFFE);
    smp();
    check("pre_wrap_pc", OutPC, 16'h000F);
    afterJump(16'hFFFE);
    go(); smp();
    check("wrap_ffff", OutPC, 16'hFFFF);
    go(); doJump(1'b0, 1'b1, 16'h0002);
    smp();
    check("wrap_0000_valid", OutValid, 1);
    check("wrap_0000_pc", OutPC, 16'h0000);
    afterJump(16'hFFFE);
    go(); doJump(1'b0, 1'b0, 16'h0003);
    smp();
    check("wrap_add_head", OutPC, 16'hFFFF);
    afterJump(16'h0002);

    // 2-word instruction: held back until both words are queued
    ram[0] = 16'h5123; ram[1] = 16'hBEEF;
    go(); doJump(1'b1, 1'b0, 16'h0000);
    smp();
    check("pre_long_pc", OutPC, 16'h0003);
    go(); JumpFlag = 1'b0;
    smp(); check("long_t1_valid", OutValid, 0);
    go(); smp(); check("long_t2_valid", OutValid, 0);
    go(); smp();
    check("long_split_valid", OutValid, 0);
    check("long_split_data", OutDataBus, 0);
    check("long_split_long", OutLong, 0);
    go(); smp();
    check("long_valid", OutValid, 1);
    check("long_data", OutDataBus, 32'hBEEF_5123);
    check("long_flag", OutLong, 1);
    check("long_pc", OutPC, 16'h0000);
    go(); smp();
    check("after_long_pc", OutPC, 16'h0002);
    check("after_long_flag", OutLong, 0);
    check("after_long_data", OutDataBus, 32'h0000_1002);

    // One-cycle reset mid-stream with a read in flight
    ram[0] = 16'h1000; ram[1] = 16'h1001;
    go(); nReset = 1'b0;
    smp();
    check("mrst_valid", OutValid, 0);
    check("mrst_req", MemReq, 0);
    check("mrst_pc", OutPC, 0);
    check("mrst_data", OutDataBus, 0);
    go(); nReset = 1'b1;
    smp();
    check("mrst_c0_valid", OutValid, 0);
    check("mrst_c0_addr", MemAddr, 16'h0000);
    check("mrst_c0_req", MemReq, 1);
    go(); smp();
    check("mrst_c1_valid", OutValid, 0);
    go(); smp();
    check("mrst_c2_valid", OutValid, 1);
    check("mrst_c2_pc", OutPC, 16'h0000);
    check("mrst_c2_data", OutDataBus, 32'h0000_1000);
    go(); smp();
    check("mrst_c3_pc", OutPC, 16'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
